// File: rtl/fir_ctrl.sv
// Sample-rate controller that paces ADC requests into a FIR filter.
// It also double-buffers the tap coefficients.
module fir_ctrl #(
  parameter int DIV     = 1000,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         coef_wr,
  input  logic [3:0]   coef_addr,
  input  logic [11:0]  coef_data,
  input  logic         coef_commit,
  output logic         adc_req,
  input  logic         adc_valid,
  input  logic [11:0]  adc_data,
  output logic [11:0]  fir_data,
  output logic         fir_ready,
  output logic         fir_en,
  output logic [191:0] coef_bus,
  output logic         filt_valid,
  output logic         busy,
  output logic         overrun,
  output logic         timeout_err,
  output logic [15:0]  sample_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [15:0]   DIV_M1 = 16'(DIV - 1);
  localparam logic [TW-1:0] TMO_M1 = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_REQ, S_STROBE
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   smp_q, smp_d;
  logic [11:0]   data_q, data_d;
  logic          ovr_q, ovr_d;
  logic          terr_q, terr_d;
  logic          req_q, rdy_q, en_q;
  logic [1:0]    fvp_q, fvp_d;
  logic          fv_q, fv_d;
  logic          pend_q, pend_d;
  logic [11:0]   shadow_q [16];
  logic [11:0]   shadow_d [16];
  logic [11:0]   active_q [16];

  logic tick, go, capture, tmo_hit, copy;

  assign tick    = (state_q != S_IDLE) && (cnt_q == DIV_M1);
  assign go      = (state_q == S_IDLE) && start && !stop;
  assign capture = (state_q == S_REQ) && !stop && adc_valid;
  assign tmo_hit = (state_q == S_REQ) && !stop && !adc_valid
                 && (tmo_q == TMO_M1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (go) state_d = S_WAIT;
      S_WAIT: begin
        if (stop)      state_d = S_IDLE;
        else if (tick) state_d = S_REQ;
      end
      S_REQ: begin
        if (stop)         state_d = S_IDLE;
        else if (capture) state_d = S_STROBE;
        else if (tmo_hit) state_d = S_WAIT;
      end
      S_STROBE: state_d = stop ? S_IDLE : S_WAIT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q + 16'd1;
    if (state_q == S_IDLE || state_d == S_IDLE || tick)
      cnt_d = '0;
    tmo_d  = (state_q == S_REQ) ? tmo_q + 1'b1 : '0;
    ovr_d  = go ? 1'b0 : ovr_q | ((state_q == S_REQ) && tick);
    terr_d = go ? 1'b0 : terr_q | tmo_hit;
    smp_d  = smp_q;
    if (go)
      smp_d = '0;
    else if (state_d == S_STROBE && smp_q != 16'hFFFF)
      smp_d = smp_q + 16'd1;
    data_d = capture ? adc_data : data_q;
    // a stop kills any filt_valid still in flight
    fvp_d  = '0;
    fv_d   = 1'b0;
    if (state_d != S_IDLE) begin
      fvp_d = {fvp_q[0], rdy_q && (smp_q >= 16'd16)};
      fv_d  = fvp_q[1];
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (coef_wr) shadow_d[coef_addr] = coef_data;
    copy = ((state_q == S_IDLE) && coef_commit)
        || ((state_q == S_WAIT) && tick && (pend_q || coef_commit));
    pend_d = copy ? 1'b0
                  : pend_q | (coef_commit && state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      smp_q   <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      terr_q  <= 1'b0;
      req_q   <= 1'b0;
      rdy_q   <= 1'b0;
      en_q    <= 1'b0;
      fvp_q   <= '0;
      fv_q    <= 1'b0;
      pend_q  <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      smp_q    <= smp_d;
      data_q   <= data_d;
      ovr_q    <= ovr_d;
      terr_q   <= terr_d;
      req_q    <= (state_d == S_REQ);
      rdy_q    <= (state_d == S_STROBE);
      en_q     <= (state_d != S_IDLE);
      fvp_q    <= fvp_d;
      fv_q     <= fv_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      if (copy) active_q <= shadow_d;
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_bus
    assign coef_bus[12*k +: 12] = active_q[k];
  end

  assign adc_req     = req_q;
  assign fir_ready   = rdy_q;
  assign fir_en      = en_q;
  assign busy        = en_q;
  assign fir_data    = data_q;
  assign filt_valid  = fv_q;
  assign overrun     = ovr_q;
  assign timeout_err = terr_q;
  assign sample_cnt  = smp_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Bench for fir_ctrl: vector table, strobe scoreboard,
// plus overrun, timeout, stop and reset sequences.
module tb_fir_ctrl;

  localparam int DIV = 8;
  localparam int TMO = 12;
  localparam int NV  = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         coef_wr = 1'b0;
  logic [3:0]   coef_addr = '0;
  logic [11:0]  coef_data = '0;
  logic         coef_commit = 1'b0;
  logic         adc_valid = 1'b0;
  logic [11:0]  adc_data = '0;
  logic         adc_req, fir_ready, fir_en, filt_valid;
  logic         busy, overrun, timeout_err;
  logic [11:0]  fir_data;
  logic [191:0] coef_bus;
  logic [15:0]  sample_cnt;

  fir_ctrl #(.DIV(DIV), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .coef_wr(coef_wr), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_commit(coef_commit),
    .adc_req(adc_req), .adc_valid(adc_valid),
    .adc_data(adc_data), .fir_data(fir_data),
    .fir_ready(fir_ready), .fir_en(fir_en),
    .coef_bus(coef_bus), .filt_valid(filt_valid),
    .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    int          lat;
    logic [15:0] cnt;
    logic        fv;
  } vec_t;

  typedef struct {
    logic [11:0] data;
    logic [15:0] cnt;
  } exp_t;

  vec_t vec [NV];
  exp_t sb [$];
  int   n_run = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] tap(input int k);
    return coef_bus[12*k +: 12];
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (adc_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_run++;
      n_fail++;
      $display("FAIL wait_req: adc_req got 0 expected 1 within 40 cycles");
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && fir_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL strobe: got fir_ready cnt=%0d expected none",
                 sample_cnt);
      end else begin
        e = sb.pop_front();
        chk("sb fir_data", 32'(fir_data), 32'(e.data));
        chk("sb sample_cnt", 32'(sample_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit fv;
    int last;
    int n;

    for (int i = 0; i < NV; i++) begin
      vec[i].data = 12'($urandom);
      vec[i].lat  = (i % 5 == 3) ? 3 : ((i % 7 == 6) ? 1 : 2);
      vec[i].cnt  = 16'(i + 1);
      vec[i].fv   = (i >= 15);
    end
    last = 0;

    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 0);
    chk("rst fir_en", 32'(fir_en), 0);
    chk("rst adc_req", 32'(adc_req), 0);
    chk("rst fir_ready", 32'(fir_ready), 0);
    chk("rst filt_valid", 32'(filt_valid), 0);
    chk("rst overrun", 32'(overrun), 0);
    chk("rst timeout_err", 32'(timeout_err), 0);
    chk("rst sample_cnt", 32'(sample_cnt), 0);
    chk("rst fir_data", 32'(fir_data), 0);
    chk("rst coef_bus zero", 32'(coef_bus == '0), 1);
    rst = 1'b1;
    @(negedge clk);

    coef_wr = 1'b1; coef_addr = 4'd3; coef_data = 12'h123;
    @(negedge clk);
    coef_wr = 1'b0;
    chk("write w/o commit", 32'(tap(3)), 0);
    coef_wr = 1'b1; coef_addr = 4'd5; coef_data = 12'h321;
    coef_commit = 1'b1;
    @(negedge clk);
    coef_wr = 1'b0; coef_commit = 1'b0;
    chk("idle commit tap5", 32'(tap(5)), 32'h321);
    chk("idle commit tap3", 32'(tap(3)), 32'h123);
    chk("idle busy", 32'(busy), 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run busy", 32'(busy), 1);
    chk("run fir_en", 32'(fir_en), 1);
    chk("run adc_req", 32'(adc_req), 0);

    for (int i = 0; i < NV; i++) begin
      wait_req(ok);
      if (!ok) break;
      if (i == 5) chk("run commit applied", 32'(tap(5)), 32'h7FF);
      repeat (vec[i].lat) @(negedge clk);
      adc_valid = 1'b1;
      adc_data  = vec[i].data;
      sb.push_back('{vec[i].data, vec[i].cnt});
      @(negedge clk);
      adc_valid = 1'b0;
      chk("fir_ready", 32'(fir_ready), 1);
      if (i > 0)
        chk("period", cyc - last, DIV + vec[i].lat - vec[i-1].lat);
      last = cyc;
      if (i == 4) begin
        coef_wr = 1'b1; coef_addr = 4'd5; coef_data = 12'h7FF;
        coef_commit = 1'b1;
      end
      @(negedge clk);
      coef_wr = 1'b0; coef_commit = 1'b0;
      repeat (2) @(negedge clk);
      chk("filt_valid", 32'(filt_valid), 32'(vec[i].fv));
      if (i == 4) chk("run commit held", 32'(tap(5)), 32'h321);
    end
    chk("run overrun", 32'(overrun), 0);
    chk("run timeout_err", 32'(timeout_err), 0);

    wait_req(ok);
    repeat (10) @(negedge clk);
    adc_valid = 1'b1;
    adc_data  = 12'hA5C;
    sb.push_back('{12'hA5C, 16'd21});
    @(negedge clk);
    adc_valid = 1'b0;
    chk("ovr overrun", 32'(overrun), 1);
    chk("ovr timeout_err", 32'(timeout_err), 0);
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("stop fir_en", 32'(fir_en), 0);
    chk("stop busy", 32'(busy), 0);
    chk("stop adc_req", 32'(adc_req), 0);
    chk("stop overrun sticky", 32'(overrun), 1);
    chk("stop sample_cnt", 32'(sample_cnt), 21);
    fv = 1'b0;
    repeat (4) begin
      if (filt_valid === 1'b1) fv = 1'b1;
      @(negedge clk);
    end
    chk("filt_valid suppressed", 32'(fv), 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart overrun clr", 32'(overrun), 0);
    chk("restart sample_cnt", 32'(sample_cnt), 0);
    wait_req(ok);
    n = 0;
    while (adc_req === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("tmo req width", n, TMO);
    chk("tmo timeout_err", 32'(timeout_err), 1);
    chk("tmo sample_cnt", 32'(sample_cnt), 0);

    wait_req(ok);
    #2 rst = 1'b0;
    #1;
    chk("async adc_req", 32'(adc_req), 0);
    chk("async busy", 32'(busy), 0);
    chk("async timeout_err", 32'(timeout_err), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post-rst idle", 32'(busy), 0);
    chk("post-rst coef_bus", 32'(coef_bus == '0), 1);
    chk("sb drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
